extram_arbiter: RTL and testbench

EXTRAM_ARBITER -- requirements
Module: extram_arbiter

---
 rtl/extram_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_extram_arbiter.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/extram_arbiter.sv
// extram_arbiter: shares one async SRAM between a VGA fetcher and a CPU.
// Optional stall counter: define EXTRAM_ARB_STALL_STATS_EN to build it.
module extram_arbiter (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic [18:0] I_wb_adr,
  input  logic [7:0]  I_wb_dat,
  input  logic        I_wb_stb,
  input  logic        I_wb_we,
  output logic        O_wb_ack,
  output logic [7:0]  O_wb_dat,
  input  logic        I_vga_req,
  input  logic [18:0] I_vga_adr,
  output logic [7:0]  O_vga_dat,
  output logic [18:0] O_sram_adr,
  output logic [7:0]  O_sram_dat,
  input  logic [7:0]  I_sram_dat,
  output logic        O_sram_dat_oe,
  output logic        O_sram_ce_n,
  output logic        O_sram_oe_n,
  output logic        O_sram_we_n,
  output logic [15:0] O_stall_cnt
);

  typedef enum logic [2:0] {
    C_IDLE, C_READ, C_WSETUP, C_WPULSE, C_ACK
  } cstate_t;

  cstate_t     state_q, state_d;
  logic        own_cpu_q, own_cpu_d;
  logic [18:0] adr_q, adr_d;
  logic [7:0]  wdat_q, wdat_d;
  logic        ack_q, ack_d;
  logic [7:0]  rdat_q, rdat_d;
  logic [18:0] sadr_q, sadr_d;
  logic [7:0]  sdat_q, sdat_d;
  logic        doe_q, doe_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;

  // CPU FSM: only advances past a bus state when the CPU owned that cycle
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
    unique case (state_q)
      C_IDLE: begin
        if (I_wb_stb) begin
          adr_d   = I_wb_adr;
          wdat_d  = I_wb_dat;
          state_d = I_wb_we ? C_WSETUP : C_READ;
        end
      end
      C_READ: begin
        if (own_cpu_q) begin
          rdat_d  = I_sram_dat;
          ack_d   = 1'b1;
          state_d = C_ACK;
        end
      end
      // a VGA grab right after setup forces the setup to be redone
      C_WSETUP: begin
        if (own_cpu_q && !I_vga_req)
          state_d = C_WPULSE;
      end
      C_WPULSE: begin
        ack_d   = 1'b1;
        state_d = C_ACK;
      end
      C_ACK:   state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  // Bus owner for the next cycle: VGA first, then CPU, else idle
  always_comb begin
    sadr_d    = sadr_q;
    sdat_d    = sdat_q;
    doe_d     = 1'b0;
    ce_n_d    = 1'b1;
    oe_n_d    = 1'b1;
    we_n_d    = 1'b1;
    own_cpu_d = 1'b0;
    if (I_vga_req) begin
      sadr_d = I_vga_adr;
      ce_n_d = 1'b0;
      oe_n_d = 1'b0;
    end else begin
      unique case (state_d)
        C_READ: begin
          sadr_d    = adr_d;
          ce_n_d    = 1'b0;
          oe_n_d    = 1'b0;
          own_cpu_d = 1'b1;
        end
        C_WSETUP, C_WPULSE: begin
          sadr_d    = adr_d;
          sdat_d    = wdat_d;
          doe_d     = 1'b1;
          ce_n_d    = 1'b0;
          we_n_d    = (state_d != C_WPULSE);
          own_cpu_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // State and registered SRAM/CPU outputs
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_q   <= C_IDLE;
      own_cpu_q <= 1'b0;
      adr_q     <= '0;
      wdat_q    <= '0;
      ack_q     <= 1'b0;
      rdat_q    <= '0;
      sadr_q    <= '0;
      sdat_q    <= '0;
      doe_q     <= 1'b0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      own_cpu_q <= own_cpu_d;
      adr_q     <= adr_d;
      wdat_q    <= wdat_d;
      ack_q     <= ack_d;
      rdat_q    <= rdat_d;
      sadr_q    <= sadr_d;
      sdat_q    <= sdat_d;
      doe_q     <= doe_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
    end
  end

  assign O_wb_ack      = ack_q;
  assign O_wb_dat      = rdat_q;
  assign O_vga_dat     = I_sram_dat;
  assign O_sram_adr    = sadr_q;
  assign O_sram_dat    = sdat_q;
  assign O_sram_dat_oe = doe_q;
  assign O_sram_ce_n   = ce_n_q;
  assign O_sram_oe_n   = oe_n_q;
  assign O_sram_we_n   = we_n_q;

`ifdef EXTRAM_ARB_STALL_STATS_EN
  logic        vga_own_q;
  logic [15:0] stall_q, stall_d;
  logic        stall_inc;

  assign stall_inc = vga_own_q &&
    (state_q == C_READ || state_q == C_WSETUP ||
     (state_q == C_IDLE && I_wb_stb));

  // Saturating count of VGA cycles that held off a waiting CPU
  always_comb begin
    stall_d = stall_q;
    if (stall_inc && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  // Stall counter and VGA-ownership register
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      vga_own_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      vga_own_q <= I_vga_req;
      stall_q   <= stall_d;
    end
  end

  assign O_stall_cnt = stall_q;
`else
  assign O_stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_extram_arbiter.sv
// tb_extram_arbiter: scoreboard bench for extram_arbiter.
// Async SRAM model plus bus-protocol monitor.
module tb_extram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [18:0] wb_adr;
  logic [7:0]  wb_dat;
  logic        wb_stb;
  logic        wb_we;
  logic        wb_ack;
  logic [7:0]  wb_rdat;
  logic        vga_req;
  logic [18:0] vga_adr;
  logic [7:0]  vga_dat;
  logic [18:0] sram_adr;
  logic [7:0]  sram_wdat;
  logic [7:0]  sram_rd;
  logic        dat_oe;
  logic        ce_n;
  logic        oe_n;
  logic        we_n;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  extram_arbiter dut (
    .I_clk         (clk),
    .I_reset       (rst),
    .I_wb_adr      (wb_adr),
    .I_wb_dat      (wb_dat),
    .I_wb_stb      (wb_stb),
    .I_wb_we       (wb_we),
    .O_wb_ack      (wb_ack),
    .O_wb_dat      (wb_rdat),
    .I_vga_req     (vga_req),
    .I_vga_adr     (vga_adr),
    .O_vga_dat     (vga_dat),
    .O_sram_adr    (sram_adr),
    .O_sram_dat    (sram_wdat),
    .I_sram_dat    (sram_rd),
    .O_sram_dat_oe (dat_oe),
    .O_sram_ce_n   (ce_n),
    .O_sram_oe_n   (oe_n),
    .O_sram_we_n   (we_n),
    .O_stall_cnt   (stall_cnt)
  );

  int n_chk = 0;
  int n_fail = 0;
  int viol = 0;
  int we_pulses = 0;
  int acks = 0;
  logic [7:0]  pulse_dat;
  logic [18:0] pulse_adr;

  logic [7:0] vga_q[$];
  logic [7:0] cpu_q[$];
  logic [7:0] ref_mem[int];

  logic [7:0] sram [0:524287];
  bit         sram_wr [0:524287];

  function automatic logic [7:0] pat(input logic [18:0] a);
    return a[7:0] ^ {a[18:16], a[12:8]} ^ 8'h3C;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [18:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return pat(a);
  endfunction

  assign sram_rd = (!ce_n && !oe_n) ?
    (sram_wr[sram_adr] ? sram[sram_adr] : pat(sram_adr)) : 8'hEE;

  always @(posedge clk) begin
    if (ce_n == 1'b0 && we_n == 1'b0) begin
      sram[sram_adr]    <= sram_wdat;
      sram_wr[sram_adr] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (we_n == 1'b0 && oe_n == 1'b0) viol <= viol + 1;
    if (dat_oe == 1'b1 && oe_n == 1'b0) viol <= viol + 1;
    if (ce_n == 1'b0 && we_n == 1'b0) begin
      we_pulses <= we_pulses + 1;
      pulse_dat <= sram_wdat;
      pulse_adr <= sram_adr;
    end
    if (wb_ack == 1'b1) acks <= acks + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // drive one CPU access; lat = edges after acceptance until ack seen
  task automatic cpu_access(input logic we, input logic [18:0] a,
                            input logic [7:0] d, output int lat,
                            output logic [7:0] r);
    wb_we  = we;
    wb_adr = a;
    wb_dat = d;
    wb_stb = 1'b1;
    tick();
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!wb_ack && lat < 40);
    r = wb_rdat;
    wb_stb = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    n_chk++;
    if ({ce_n, oe_n, we_n} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b expected 111", {ce_n, oe_n, we_n});
    end
    n_chk++;
    if ({wb_ack, dat_oe} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ack_oe: got %b expected 00", {wb_ack, dat_oe});
    end
    n_chk++;
    if ({sram_adr, sram_wdat, wb_rdat} !== 35'h0) begin
      n_fail++;
      $display("FAIL reset_regs: got %h expected 0",
               {sram_adr, sram_wdat, wb_rdat});
    end
    n_chk++;
    if (stall_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_stall: got %h expected 0", stall_cnt);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write;
    int lat;
    int p0;
    logic [7:0] r;
    p0 = we_pulses;
    ref_mem[int'(19'h20010)] = 8'h5A;
    cpu_access(1'b1, 19'h20010, 8'h5A, lat, r);
    tick();
    n_chk++;
    if (lat + 1 != 3) begin
      n_fail++;
      $display("FAIL write_ack_edge: got %0d expected 3", lat + 1);
    end
    n_chk++;
    if (we_pulses - p0 != 1) begin
      n_fail++;
      $display("FAIL write_pulses: got %0d expected 1", we_pulses - p0);
    end
    n_chk++;
    if ({pulse_adr, pulse_dat} !== {19'h20010, 8'h5A}) begin
      n_fail++;
      $display("FAIL write_pulse_bus: got %h/%h expected 20010/5a",
               pulse_adr, pulse_dat);
    end
  endtask

  task automatic test_read;
    int lat;
    logic [7:0] r;
    logic [7:0] e;
    cpu_q.push_back(ref_rd(19'h20010));
    cpu_access(1'b0, 19'h20010, 8'h00, lat, r);
    e = cpu_q.pop_front();
    n_chk++;
    if (r !== e) begin
      n_fail++;
      $display("FAIL read_data: got %h expected %h", r, e);
    end
    n_chk++;
    if (lat + 1 != 2) begin
      n_fail++;
      $display("FAIL read_ack_edge: got %0d expected 2", lat + 1);
    end
    tick();
    n_chk++;
    if (wb_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_one_cycle: got %b expected 0", wb_ack);
    end
  endtask

  task automatic test_vga_interleave;
    int lat;
    logic [7:0] r;
    logic [7:0] e;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          vga_req = (i % 2 == 0);
          vga_adr = 19'h20000 + 19'(i / 2);
          if (vga_req) vga_q.push_back(ref_rd(vga_adr));
          tick();
          if (i % 2 == 0) begin
            @(negedge clk);
            e = vga_q.pop_front();
            n_chk++;
            if (vga_dat !== e) begin
              n_fail++;
              $display("FAIL vga_data_%0d: got %h expected %h",
                       i / 2, vga_dat, e);
            end
          end
        end
        vga_req = 1'b0;
      end
      begin
        tick();
        cpu_q.push_back(ref_rd(19'h20010));
        cpu_access(1'b0, 19'h20010, 8'h00, lat, r);
        e = cpu_q.pop_front();
        n_chk++;
        if (r !== e || lat + 1 > 4) begin
          n_fail++;
          $display("FAIL interleave_read: got %h/%0d expected %h/<=4",
                   r, lat + 1, e);
        end
      end
    join
    tick();
  endtask

  task automatic test_starve;
    int a0;
    int lat;
    logic [7:0] e;
    logic [7:0] r;
    a0 = acks;
    ref_mem[int'(19'h20020)] = 8'hC3;
    wb_we  = 1'b1;
    wb_adr = 19'h20020;
    wb_dat = 8'hC3;
    wb_stb = 1'b1;
    for (int i = 0; i < 20; i++) begin
      vga_req = 1'b1;
      vga_adr = 19'h30000 + 19'(i);
      vga_q.push_back(ref_rd(vga_adr));
      tick();
      @(negedge clk);
      e = vga_q.pop_front();
      n_chk++;
      if (vga_dat !== e) begin
        n_fail++;
        $display("FAIL starve_vga_%0d: got %h expected %h", i, vga_dat, e);
      end
    end
    vga_req = 1'b0;
    n_chk++;
    if (acks != a0) begin
      n_fail++;
      $display("FAIL starve_no_ack: got %0d expected 0", acks - a0);
    end
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!wb_ack && lat < 20);
    wb_stb = 1'b0;
    n_chk++;
    if (!wb_ack || lat > 3) begin
      n_fail++;
      $display("FAIL starve_release: got ack=%b lat=%0d expected 1/<=3",
               wb_ack, lat);
    end
    tick();
    cpu_q.push_back(ref_rd(19'h20020));
    cpu_access(1'b0, 19'h20020, 8'h00, lat, r);
    e = cpu_q.pop_front();
    n_chk++;
    if (r !== e) begin
      n_fail++;
      $display("FAIL starve_readback: got %h expected %h", r, e);
    end
    tick();
  endtask

  task automatic test_preempt_setup;
    int p0;
    int a0;
    int s0;
    int exp_stall;
    int lat;
    logic [7:0] e;
`ifdef EXTRAM_ARB_STALL_STATS_EN
    exp_stall = 1;
`else
    exp_stall = 0;
`endif
    p0 = we_pulses;
    a0 = acks;
    s0 = int'(stall_cnt);
    ref_mem[int'(19'h20030)] = 8'h77;
    wb_we  = 1'b1;
    wb_adr = 19'h20030;
    wb_dat = 8'h77;
    wb_stb = 1'b1;
    tick();
    n_chk++;
    if ({dat_oe, we_n, oe_n} !== 3'b111) begin
      n_fail++;
      $display("FAIL preempt_setup1: got %b expected 111",
               {dat_oe, we_n, oe_n});
    end
    vga_req = 1'b1;
    vga_adr = 19'h20031;
    vga_q.push_back(ref_rd(vga_adr));
    tick();
    vga_req = 1'b0;
    n_chk++;
    if ({ce_n, oe_n, we_n, dat_oe, sram_adr} !== {4'b0010, 19'h20031}) begin
      n_fail++;
      $display("FAIL preempt_vga_cycle: got %b/%h expected 0010/20031",
               {ce_n, oe_n, we_n, dat_oe}, sram_adr);
    end
    @(negedge clk);
    e = vga_q.pop_front();
    n_chk++;
    if (vga_dat !== e) begin
      n_fail++;
      $display("FAIL preempt_vga_data: got %h expected %h", vga_dat, e);
    end
    tick();
    n_chk++;
    if ({dat_oe, we_n, oe_n, sram_adr} !== {3'b111, 19'h20030}) begin
      n_fail++;
      $display("FAIL preempt_setup2: got %b/%h expected 111/20030",
               {dat_oe, we_n, oe_n}, sram_adr);
    end
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!wb_ack && lat < 20);
    wb_stb = 1'b0;
    tick();
    tick();
    n_chk++;
    if (we_pulses - p0 != 1 || acks - a0 != 1) begin
      n_fail++;
      $display("FAIL preempt_counts: got pulses=%0d acks=%0d expected 1/1",
               we_pulses - p0, acks - a0);
    end
    n_chk++;
    if (int'(stall_cnt) - s0 != exp_stall) begin
      n_fail++;
      $display("FAIL preempt_stall: got %0d expected %0d",
               int'(stall_cnt) - s0, exp_stall);
    end
  endtask

  task automatic test_reset_wpulse;
    int a0;
    int lat;
    logic [7:0] old;
    logic [7:0] r;
    old = ref_rd(19'h20040);
    wb_we  = 1'b1;
    wb_adr = 19'h20040;
    wb_dat = 8'h99;
    wb_stb = 1'b1;
    tick();
    tick();
    n_chk++;
    if (we_n !== 1'b0) begin
      n_fail++;
      $display("FAIL rstw_in_pulse: got %b expected 0", we_n);
    end
    rst = 1'b1;
    wb_stb = 1'b0;
    a0 = acks;
    tick();
    n_chk++;
    if ({we_n, ce_n, wb_ack} !== 3'b110) begin
      n_fail++;
      $display("FAIL rstw_after: got %b expected 110", {we_n, ce_n, wb_ack});
    end
    rst = 1'b0;
    tick();
    tick();
    n_chk++;
    if (acks != a0) begin
      n_fail++;
      $display("FAIL rstw_no_ack: got %0d expected 0", acks - a0);
    end
    cpu_access(1'b0, 19'h20040, 8'h00, lat, r);
    n_chk++;
    if (r !== old && r !== 8'h99) begin
      n_fail++;
      $display("FAIL rstw_readback: got %h expected %h or 99", r, old);
    end
    tick();
  endtask

  task automatic test_strobe_sanity;
    n_chk++;
    if (viol != 0) begin
      n_fail++;
      $display("FAIL strobe_overlap: got %0d expected 0", viol);
    end
  endtask

  initial begin
    rst     = 1'b1;
    wb_adr  = '0;
    wb_dat  = '0;
    wb_stb  = 1'b0;
    wb_we   = 1'b0;
    vga_req = 1'b0;
    vga_adr = '0;
    test_reset();
    test_write();
    test_read();
    test_vga_interleave();
    test_starve();
    test_preempt_setup();
    test_reset_wpulse();
    test_strobe_sanity();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
